mem_read_arbiter: RTL and testbench

//  - Shares the single AXI4-lite memory read port between the IFU (instruction fetch) and the LSU (load path).
//  - Sits between both masters and the memory/SRAM slave. The LSU write channel bypasses this block.
//  - Grants one master per transaction and holds the grant from AR handshake through R handshake; never interleaves.

---
 rtl/mem_read_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter
// Brief    : Shares one AXI4-lite read port between IFU and LSU; one owner per
//            AR..R transaction. Define ARB_ROUND_ROBIN_EN for round-robin ties
//            (default: LSU wins ties).
// Revision : 1.0
// ============================================================================
module mem_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic [1:0]        grant
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IFU_AR = 3'd1,
    S_IFU_R  = 3'd2,
    S_LSU_AR = 3'd3,
    S_LSU_R  = 3'd4
  } state_t;

  state_t r_state;
  logic   w_tie_lsu;
  logic   w_pick_lsu;
  logic   w_ar_hs;
  logic   w_r_hs;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_lsu;
  // On a tie the master that did not own the port last time wins.
  assign w_tie_lsu = ~r_last_lsu;
`else
  assign w_tie_lsu = 1'b1;
`endif

  assign w_pick_lsu = lsu_arvalid & (~ifu_arvalid | w_tie_lsu);
  assign w_ar_hs    = mem_arvalid & mem_arready;
  assign w_r_hs     = mem_rvalid & mem_rready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_lsu <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ifu_arvalid | lsu_arvalid) begin
            r_state <= w_pick_lsu ? S_LSU_AR : S_IFU_AR;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_lsu <= w_pick_lsu;
`endif
          end
        end
        S_IFU_AR: if (w_ar_hs) r_state <= S_IFU_R;
        S_IFU_R:  if (w_r_hs)  r_state <= S_IDLE;
        S_LSU_AR: if (w_ar_hs) r_state <= S_LSU_R;
        S_LSU_R:  if (w_r_hs)  r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Routing is a pure decode of the owner state; everything idles at zero.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    grant       = 2'b00;
    case (r_state)
      S_IFU_AR: begin
        grant       = 2'b01;
        mem_araddr  = ifu_araddr;
        mem_arvalid = ifu_arvalid;
        ifu_arready = mem_arready;
      end
      S_IFU_R: begin
        grant      = 2'b01;
        ifu_rvalid = mem_rvalid;
        ifu_rdata  = mem_rdata;
        ifu_rresp  = mem_rresp;
        mem_rready = ifu_rready;
      end
      S_LSU_AR: begin
        grant       = 2'b10;
        mem_araddr  = lsu_araddr;
        mem_arvalid = lsu_arvalid;
        lsu_arready = mem_arready;
      end
      S_LSU_R: begin
        grant      = 2'b10;
        lsu_rvalid = mem_rvalid;
        lsu_rdata  = mem_rdata;
        lsu_rresp  = mem_rresp;
        mem_rready = lsu_rready;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_read_arbiter
// Brief    : Directed self-checking bench for mem_read_arbiter; honours
//            ARB_ROUND_ROBIN_EN for tie expectations.
// Revision : 1.0
// ============================================================================
module tb_mem_read_arbiter;

  localparam logic [31:0] c_ifu_addr = 32'h8000_0000;
  localparam logic [31:0] c_lsu_addr = 32'h8000_1000;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr, mem_araddr;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] ifu_rdata, lsu_rdata, mem_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, mem_rresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;
  bit m_last_lsu = 1'b1;

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit tie_winner_lsu();
`ifdef ARB_ROUND_ROBIN_EN
    return ~m_last_lsu;
`else
    return 1'b1;
`endif
  endfunction

  // Entered at a negedge with the FSM in IDLE and the request(s) already driven.
  // Leaves at the negedge where the FSM is back in IDLE.
  task automatic run_txn(input bit exp_lsu, input logic [31:0] data, input logic [1:0] resp,
                         input int ar_wait, input int r_wait);
    #1;
    check_value("idle_grant", grant, 2'b00);
    check_value("idle_arvalid", mem_arvalid, 1'b0);
    @(negedge clk);
    m_last_lsu = exp_lsu;
    #1;
    check_value("ar_grant", grant, exp_lsu ? 2'b10 : 2'b01);
    check_value("ar_addr", mem_araddr, exp_lsu ? c_lsu_addr : c_ifu_addr);
    check_value("ar_valid", mem_arvalid, 1'b1);
    for (int i = 0; i < ar_wait; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      #1;
      check_value("ar_wait_ready", exp_lsu ? lsu_arready : ifu_arready, 1'b0);
      check_value("ar_rbeat_ignored", exp_lsu ? lsu_rvalid : ifu_rvalid, 1'b0);
      check_value("ar_mem_rready", mem_rready, 1'b0);
      @(negedge clk);
    end
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    mem_arready = 1'b1;
    #1;
    check_value("ar_ready_owner", exp_lsu ? lsu_arready : ifu_arready, 1'b1);
    check_value("ar_ready_other", exp_lsu ? ifu_arready : lsu_arready, 1'b0);
    @(negedge clk);
    mem_arready = 1'b0;
    if (exp_lsu) begin lsu_arvalid = 1'b0; lsu_rready = 1'b0; end
    else         begin ifu_arvalid = 1'b0; ifu_rready = 1'b0; end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    mem_rresp  = resp;
    for (int i = 0; i < r_wait; i++) begin
      #1;
      check_value("r_hold_grant", grant, exp_lsu ? 2'b10 : 2'b01);
      check_value("r_hold_mem_rready", mem_rready, 1'b0);
      check_value("r_hold_rvalid", exp_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
      @(negedge clk);
    end
    if (exp_lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
    #1;
    check_value("r_mem_rready", mem_rready, 1'b1);
    check_value("r_rvalid", exp_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
    check_value("r_rdata", exp_lsu ? lsu_rdata : ifu_rdata, data);
    check_value("r_rresp", exp_lsu ? lsu_rresp : ifu_rresp, resp);
    check_value("r_other_rvalid", exp_lsu ? ifu_rvalid : lsu_rvalid, 1'b0);
    check_value("r_other_rdata", exp_lsu ? ifu_rdata : lsu_rdata, 32'h0);
    check_value("r_other_rresp", exp_lsu ? ifu_rresp : lsu_rresp, 2'b00);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_rresp  = 2'b00;
    ifu_rready = 1'b0;
    lsu_rready = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    ifu_araddr  = c_ifu_addr;
    lsu_araddr  = c_lsu_addr;
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    mem_arready = 1'b1;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h5555_5555;
    mem_rresp   = 2'b11;

    // Reset held with every input active: nothing may leak through.
    repeat (2) @(negedge clk);
    #1;
    check_value("rst_grant", grant, 2'b00);
    check_value("rst_mem_arvalid", mem_arvalid, 1'b0);
    check_value("rst_mem_araddr", mem_araddr, 32'h0);
    check_value("rst_ifu_arready", ifu_arready, 1'b0);
    check_value("rst_lsu_arready", lsu_arready, 1'b0);
    check_value("rst_mem_rready", mem_rready, 1'b0);
    check_value("rst_ifu_rvalid", ifu_rvalid, 1'b0);
    check_value("rst_lsu_rvalid", lsu_rvalid, 1'b0);
    check_value("rst_ifu_rdata", ifu_rdata, 32'h0);
    check_value("rst_lsu_rresp", lsu_rresp, 2'b00);

    @(negedge clk);
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    mem_rresp   = 2'b00;
    ifu_rready  = 1'b0;
    lsu_rready  = 1'b0;
    rst         = 1'b1;

    // First tie after reset, with R backpressure; the loser follows after a dead cycle.
    begin
      bit w;
      w = tie_winner_lsu();
      run_txn(w, 32'h1111_2222, 2'b00, 1, 3);
      run_txn(~w, 32'h3333_4444, 2'b00, 0, 0);
    end

    // IFU alone, slave AR ready after 2 cycles.
    ifu_arvalid = 1'b1;
    run_txn(1'b0, 32'h0000_0413, 2'b00, 2, 0);

    // Error response forwarded unchanged.
    ifu_arvalid = 1'b1;
    run_txn(1'b0, 32'hCAFE_0001, 2'b10, 0, 1);

    // LSU alone.
    lsu_arvalid = 1'b1;
    run_txn(1'b1, 32'h0BAD_F00D, 2'b01, 1, 2);

    // Three back-to-back ties.
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit w;
      w = tie_winner_lsu();
      run_txn(w, 32'hA000_0000 + k, 2'b00, 0, 0);
      if (w) lsu_arvalid = 1'b1; else ifu_arvalid = 1'b1;
    end
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-transaction returns to IDLE without a clock edge.
    ifu_arvalid = 1'b1;
    @(negedge clk);
    #1;
    check_value("pre_areset_grant", grant, 2'b01);
    #1;
    rst = 1'b0;
    #1;
    check_value("areset_grant", grant, 2'b00);
    check_value("areset_mem_arvalid", mem_arvalid, 1'b0);
    @(negedge clk);
    m_last_lsu  = 1'b1;
    ifu_arvalid = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    #1;
    check_value("post_reset_idle", grant, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
